zint_gen: RTL and testbench

- Interrupt-request source stage; sits directly upstream of the Z80 interrupt controller.
- Tracks raster position from video sync strobes and compares it against programmable frame-INT coordinates.
- Produces the single-clock start pulses that the controller latches as pending requests:
  - int_start_frm: frame INT.
  - int_start_lin: line INT.
  - int_start_dma: DMA INT, on DMA completion.
- Coordinate registers are double-buffered, so CPU writes never produce a torn or double frame INT.

---
 rtl/zint_gen.sv | 168 ++++++++++++++++
 tb/tb_zint_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zint_gen.sv
// ---------------------------------------------------------------------------
// zint_gen -- interrupt-request source stage for the Z80 interrupt controller
//
// This block follows the raster position using the video sync strobes. It
// compares that position against programmable frame-INT coordinates and
// produces single-clock start pulses. The downstream interrupt controller
// latches each pulse as a pending request.
//
// Parameters
//   HW : width of the horizontal position counter and of the hsint compare
//   VW : width of the vertical line counter and of the vsint compare
//
// Ports
//   clk           system clock; all logic on the rising edge
//   res_n         asynchronous active-low reset
//   ce            horizontal tick strobe; hcnt advances only when ce=1
//   line_start    one-clk pulse at the start of every video line
//   frame_start   one-clk pulse at the start of a frame (coincides with a
//                 line_start)
//   hsint_wr      write strobe for the horizontal INT position shadow
//   vsint_wr      write strobe for the vertical INT position shadow
//   wr_data       write data; hsint takes the low HW bits
//   dma_act       DMA engine busy level
//   int_start_frm one-clk frame INT start pulse
//   int_start_lin one-clk line INT start pulse
//   int_start_dma one-clk DMA INT start pulse (on the DMA busy falling edge)
//   hcnt          current horizontal position (debug/readback)
//   vcnt          current line number (debug/readback)
// ---------------------------------------------------------------------------
module zint_gen #(
  parameter int HW = 9,
  parameter int VW = 9
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          ce,
  input  logic          line_start,
  input  logic          frame_start,
  input  logic          hsint_wr,
  input  logic          vsint_wr,
  input  logic [VW-1:0] wr_data,
  input  logic          dma_act,
  output logic          int_start_frm,
  output logic          int_start_lin,
  output logic          int_start_dma,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt
);

  localparam logic [HW-1:0] H_MAX = '1;
  localparam logic [VW-1:0] V_MAX = '1;
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [VW-1:0] V_ONE = VW'(1);

  // Shadow registers take the CPU writes. Active registers are used by the
  // comparator and change only at frame_start. This means a write can never
  // tear a coordinate pair within a frame.
  logic [HW-1:0] hs_sh;
  logic [VW-1:0] vs_sh;
  logic [HW-1:0] hs_act;
  logic [VW-1:0] vs_act;

  // Set once the frame INT has fired in the current frame. This stops a
  // repeat pulse while the counters sit saturated on the match value.
  logic fired;

  logic dma_act_r;
  logic match;
  logic [HW-1:0] hs_wdata;

  // Horizontal write data. Normally this is the low HW bits of the bus. It
  // is zero-extended if the horizontal field is wider than the bus.
  generate
    if (HW <= VW) begin : g_hs_narrow
      assign hs_wdata = wr_data[HW-1:0];
    end else begin : g_hs_wide
      assign hs_wdata = {{(HW-VW){1'b0}}, wr_data};
    end
  endgenerate

  // Shadow coordinate registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hs_sh <= '0;
      vs_sh <= '0;
    end else begin
      if (hsint_wr) hs_sh <= hs_wdata;
      if (vsint_wr) vs_sh <= wr_data;
    end
  end

  // Activation samples the shadow value from before the edge. A write that
  // lands together with frame_start therefore takes effect one frame later.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hs_act <= '0;
      vs_act <= '0;
    end else if (frame_start) begin
      hs_act <= hs_sh;
      vs_act <= vs_sh;
    end
  end

  // Horizontal counter. It restarts on every line and saturates at
  // all-ones, so a very long line cannot wrap back onto a low target.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hcnt <= '0;
    end else if (line_start) begin
      hcnt <= '0;
    end else if (ce && (hcnt != H_MAX)) begin
      hcnt <= hcnt + H_ONE;
    end
  end

  // Vertical counter. frame_start wins over the line_start that
  // accompanies it, and the counter saturates like hcnt.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      vcnt <= '0;
    end else if (frame_start) begin
      vcnt <= '0;
    end else if (line_start && (vcnt != V_MAX)) begin
      vcnt <= vcnt + V_ONE;
    end
  end

  // Compare against the registered counters. The match is suppressed on
  // sync cycles because the counters are about to be cleared there.
  assign match = (vcnt == vs_act) && (hcnt == hs_act) && !fired &&
                 !frame_start && !line_start;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      fired <= 1'b0;
    end else if (frame_start) begin
      fired <= 1'b0;
    end else if (match) begin
      fired <= 1'b1;
    end
  end

  // DMA busy delay stage, used to detect the falling edge. It resets to 0,
  // so a DMA that is already busy at reset release produces no pulse until
  // it actually finishes.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      dma_act_r <= 1'b0;
    end else begin
      dma_act_r <= dma_act;
    end
  end

  // Registered start pulses. Each one is independent of the others, and
  // priority is resolved in the controller downstream.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      int_start_frm <= 1'b0;
      int_start_lin <= 1'b0;
      int_start_dma <= 1'b0;
    end else begin
      int_start_frm <= match;
      int_start_lin <= line_start;
      int_start_dma <= dma_act_r && !dma_act;
    end
  end

endmodule

// File: tb/tb_zint_gen.sv
// ---------------------------------------------------------------------------
// tb_zint_gen -- directed self-checking bench for zint_gen
// ---------------------------------------------------------------------------
module tb_zint_gen;

  localparam int HW = 9;
  localparam int VW = 9;

  logic          clk;
  logic          res_n;
  logic          ce;
  logic          line_start;
  logic          frame_start;
  logic          hsint_wr;
  logic          vsint_wr;
  logic [VW-1:0] wr_data;
  logic          dma_act;
  logic          int_start_frm;
  logic          int_start_lin;
  logic          int_start_dma;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  int checks = 0;
  int errors = 0;
  int frm_cnt = 0;
  int lin_cnt = 0;
  int dma_cnt = 0;
  int frm_h = -1;
  int frm_v = -1;

  zint_gen #(.HW(HW), .VW(VW)) dut (
    .clk           (clk),
    .res_n         (res_n),
    .ce            (ce),
    .line_start    (line_start),
    .frame_start   (frame_start),
    .hsint_wr      (hsint_wr),
    .vsint_wr      (vsint_wr),
    .wr_data       (wr_data),
    .dma_act       (dma_act),
    .int_start_frm (int_start_frm),
    .int_start_lin (int_start_lin),
    .int_start_dma (int_start_dma),
    .hcnt          (hcnt),
    .vcnt          (vcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    frm_cnt = 0;
    lin_cnt = 0;
    dma_cnt = 0;
    frm_h = -1;
    frm_v = -1;
  endtask

  // Advance one clock and sample 1 time unit after the edge. The frame
  // pulse records the counter values seen before the edge that raised it.
  task automatic clk1();
    int ph;
    int pv;
    ph = int'(hcnt);
    pv = int'(vcnt);
    @(posedge clk);
    #1;
    if (int_start_frm === 1'b1) begin
      frm_cnt++;
      frm_h = ph;
      frm_v = pv;
    end
    if (int_start_lin === 1'b1) lin_cnt++;
    if (int_start_dma === 1'b1) dma_cnt++;
  endtask

  task automatic wr(input bit hw, input bit vw, input int data);
    hsint_wr = hw;
    vsint_wr = vw;
    wr_data = VW'(data);
    clk1();
    hsint_wr = 1'b0;
    vsint_wr = 1'b0;
  endtask

  // One video line. A line_start cycle (optionally also frame_start) is
  // followed by 'ticks' ce cycles. Any pending write strobes are dropped
  // after the sync cycle.
  task automatic run_line(input int ticks, input bit frm);
    line_start = 1'b1;
    frame_start = frm;
    ce = 1'b0;
    clk1();
    chk("lin_after_ls", {31'd0, int_start_lin}, 32'd1);
    line_start = 1'b0;
    frame_start = 1'b0;
    hsint_wr = 1'b0;
    vsint_wr = 1'b0;
    ce = 1'b1;
    for (int i = 0; i < ticks; i++) begin
      clk1();
      if (i == 0) chk("lin_one_clk", {31'd0, int_start_lin}, 32'd0);
    end
    ce = 1'b0;
  endtask

  task automatic run_frame(input int lines, input int ticks);
    run_line(ticks, 1'b1);
    for (int l = 1; l < lines; l++) run_line(ticks, 1'b0);
  endtask

  initial begin
    res_n = 1'b1;
    ce = 1'b0;
    line_start = 1'b0;
    frame_start = 1'b0;
    hsint_wr = 1'b0;
    vsint_wr = 1'b0;
    wr_data = '0;
    dma_act = 1'b0;

    // Reset: every output is 0 while reset is held.
    #3 res_n = 1'b0;
    clk1();
    clk1();
    chk("rst_frm", {31'd0, int_start_frm}, 32'd0);
    chk("rst_lin", {31'd0, int_start_lin}, 32'd0);
    chk("rst_dma", {31'd0, int_start_dma}, 32'd0);
    chk("rst_hcnt", 32'(hcnt), 32'd0);
    chk("rst_vcnt", 32'(vcnt), 32'd0);

    // Release with idle inputs. The reset targets (0,0) equal the counters,
    // so exactly one frame INT fires on the first clock and none follow.
    res_n = 1'b1;
    clr_counts();
    clk1();
    chk("idle_frm_first", {31'd0, int_start_frm}, 32'd1);
    repeat (9) clk1();
    chk("idle_frm_cnt", frm_cnt, 1);
    chk("idle_lin_cnt", lin_cnt, 0);
    chk("idle_dma_cnt", dma_cnt, 0);

    // Frame INT timing at (v=3, h=10), with 20-tick lines.
    wr(1'b0, 1'b1, 3);
    wr(1'b1, 1'b0, 10);
    clr_counts();
    run_frame(6, 20);
    chk("frm_cnt", frm_cnt, 1);
    chk("frm_v", frm_v, 3);
    chk("frm_h", frm_h, 10);
    chk("frm_lin_cnt", lin_cnt, 6);

    // Double buffer: a mid-frame write of 5 leaves this frame at line 3.
    clr_counts();
    run_line(20, 1'b1);
    run_line(20, 1'b0);
    wr(1'b0, 1'b1, 5);
    for (int l = 2; l < 6; l++) run_line(20, 1'b0);
    chk("db_cur_cnt", frm_cnt, 1);
    chk("db_cur_v", frm_v, 3);
    clr_counts();
    run_frame(6, 20);
    chk("db_next_cnt", frm_cnt, 1);
    chk("db_next_v", frm_v, 5);

    // A write coincident with frame_start is activated one frame late.
    clr_counts();
    vsint_wr = 1'b1;
    wr_data = VW'(2);
    run_frame(6, 20);
    chk("coinc_cnt", frm_cnt, 1);
    chk("coinc_v", frm_v, 5);
    clr_counts();
    run_frame(6, 20);
    chk("coinc_next_cnt", frm_cnt, 1);
    chk("coinc_next_v", frm_v, 2);

    // Saturation: target (0,511) on 600-tick lines gives a single pulse.
    wr(1'b1, 1'b1, 0);
    wr(1'b1, 1'b0, 511);
    clr_counts();
    run_line(600, 1'b1);
    chk("sat_hcnt", 32'(hcnt), 32'd511);
    run_line(600, 1'b0);
    chk("sat_cnt", frm_cnt, 1);
    chk("sat_v", frm_v, 0);
    chk("sat_h", frm_h, 511);

    // Line INT: 4 lines, the first on frame_start. The target h=511 cannot
    // be reached on these short lines.
    clr_counts();
    run_frame(4, 3);
    chk("lin_cnt", lin_cnt, 4);
    chk("lin_unreach_frm", frm_cnt, 0);
    chk("lin_vcnt", 32'(vcnt), 32'd3);
    chk("lin_hcnt", 32'(hcnt), 32'd3);

    // Asynchronous reset in mid-stream, with DMA busy across the release.
    dma_act = 1'b1;
    line_start = 1'b1;
    clk1();
    chk("pre_rst_lin", {31'd0, int_start_lin}, 32'd1);
    chk("pre_rst_vcnt", 32'(vcnt), 32'd4);
    res_n = 1'b0;
    #1;
    chk("async_rst_lin", {31'd0, int_start_lin}, 32'd0);
    chk("async_rst_vcnt", 32'(vcnt), 32'd0);
    line_start = 1'b0;
    clk1();
    clk1();
    chk("hold_rst_lin", {31'd0, int_start_lin}, 32'd0);
    chk("hold_rst_dma", {31'd0, int_start_dma}, 32'd0);
    res_n = 1'b1;
    clr_counts();
    repeat (3) clk1();
    chk("rel_busy_dma", dma_cnt, 0);
    chk("rel_early_frm", frm_cnt, 1);
    dma_act = 1'b0;
    clk1();
    chk("rel_fall_dma", {31'd0, int_start_dma}, 32'd1);
    clk1();
    chk("rel_dma_cnt", dma_cnt, 1);

    // DMA edge: a rise held for 7 clocks, then a fall gives one pulse.
    clr_counts();
    dma_act = 1'b1;
    repeat (7) clk1();
    chk("dma_rise_cnt", dma_cnt, 0);
    dma_act = 1'b0;
    clk1();
    chk("dma_fall_pulse", {31'd0, int_start_dma}, 32'd1);
    clk1();
    chk("dma_fall_end", {31'd0, int_start_dma}, 32'd0);
    chk("dma_cnt", dma_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
